// File: rtl/pwm_cmd_pkg.sv
// pwm_cmd_pkg: shared types, byte constants and ASCII helpers for the
// PWM command sequencer.
//   state_t  - sequencer FSM states
//   CMD_W/CMD_R/CR/ACK/NAK - frame and reply bytes
//   hex2nib  - ASCII hex char -> {valid, nibble}
//   nib2hex  - nibble -> upper-case ASCII hex char
//   is_digit - ASCII '0'..'9' test
package pwm_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE, GET_CH, GET_HI, GET_LO, GET_END, SKIP,
    EXEC, TX_SEND, TX_HOLD, TX_WAIT
  } state_t;

  localparam logic [7:0] CMD_W = 8'h50;  // 'P'
  localparam logic [7:0] CMD_R = 8'h52;  // 'R'
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] NAK   = 8'h3F;  // '?'

  // Bit 4 is the valid flag, bits 3:0 the nibble.
  function automatic logic [4:0] hex2nib(input logic [7:0] b);
    logic [7:0] t;
    logic       v;
    t = 8'h00;
    v = 1'b0;
    if (b >= 8'h30 && b <= 8'h39) begin
      t = b - 8'h30; v = 1'b1;
    end else if (b >= 8'h41 && b <= 8'h46) begin
      t = b - 8'h37; v = 1'b1;
    end else if (b >= 8'h61 && b <= 8'h66) begin
      t = b - 8'h57; v = 1'b1;
    end
    return {v, t[3:0]};
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/pwm_cmd_ctrl.sv
// pwm_cmd_ctrl: framed ASCII command sequencer between a UART and a bank
// of 8-bit PWM duty registers.
//   Write frame: 'P' ch hh CR  -> reply 'K'
//   Read frame : 'R' ch CR     -> reply hex-hi, hex-lo, CR
//   Bad frame  : reply '?' once the terminating CR arrives
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   rx_valid/rx_data    - received byte strobe and data
//   rx_error            - UART receive error, aborts a frame in progress
//   tx_busy             - UART transmitting
//   tx_start/tx_data    - one-cycle transmit request and its byte
//   duty                - packed duty registers, channel n at [8n+7:8n]
//   duty_wr             - one-cycle pulse on the channel just written
//   busy                - sequencer not idle
import pwm_cmd_pkg::*;

module pwm_cmd_ctrl #(
  parameter int         NUM_CH         = 4,
  parameter int         TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0] DUTY_RESET     = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_error,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [NUM_CH*8-1:0]   duty,
  output logic [NUM_CH-1:0]     duty_wr,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic                    is_wr;
  logic [3:0]              ch;
  logic [3:0]              hi, lo;
  logic [7:0]              rq [3];
  logic [1:0]              rq_idx, rq_last;
  logic [TW-1:0]           tmo;
  logic [NUM_CH-1:0][7:0]  duty_q;

  logic [4:0]              hx;
  logic [7:0]              dig;
  logic                    ch_ok;
  logic                    rx_state;
  logic                    tmo_hit;
  logic [7:0]              sel_duty;

  assign hx       = hex2nib(rx_data);
  assign dig      = rx_data - 8'h30;
  assign ch_ok    = is_digit(rx_data) && (dig < 8'(NUM_CH));
  assign rx_state = (state == GET_CH) || (state == GET_HI) || (state == GET_LO) ||
                    (state == GET_END) || (state == SKIP);
  assign tmo_hit  = (tmo == TW'(TIMEOUT_CYCLES - 1));
  assign duty     = duty_q;
  assign busy     = (state != IDLE);

  always_comb begin
    sel_duty = DUTY_RESET;
    for (int i = 0; i < NUM_CH; i++)
      if (ch == 4'(i)) sel_duty = duty_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      is_wr    <= 1'b0;
      ch       <= '0;
      hi       <= '0;
      lo       <= '0;
      rq[0]    <= '0;
      rq[1]    <= '0;
      rq[2]    <= '0;
      rq_idx   <= '0;
      rq_last  <= '0;
      tmo      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      duty_wr  <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= DUTY_RESET;
    end else begin
      tx_start <= 1'b0;
      duty_wr  <= '0;
      if (rx_state) begin
        // rx_error outranks a coincident byte and any pending timeout.
        if (rx_error) begin
          state <= IDLE;
          tmo   <= '0;
        end else if (rx_valid) begin
          tmo <= '0;
          case (state)
            GET_CH: begin
              if (ch_ok) begin
                ch    <= dig[3:0];
                state <= is_wr ? GET_HI : GET_END;
              end else state <= SKIP;
            end
            GET_HI: begin
              hi    <= hx[3:0];
              state <= hx[4] ? GET_LO : SKIP;
            end
            GET_LO: begin
              lo    <= hx[3:0];
              state <= hx[4] ? GET_END : SKIP;
            end
            GET_END: state <= (rx_data == CR) ? EXEC : SKIP;
            default: begin  // SKIP
              if (rx_data == CR) begin
                rq[0]   <= NAK;
                rq_last <= 2'd0;
                rq_idx  <= 2'd0;
                state   <= TX_SEND;
              end
            end
          endcase
        end else if (tmo_hit) begin
          state <= IDLE;
          tmo   <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end else begin
        tmo <= '0;
        case (state)
          IDLE: begin
            if (rx_valid && !rx_error) begin
              if (rx_data == CMD_W || rx_data == (CMD_W | 8'h20)) begin
                is_wr <= 1'b1;
                state <= GET_CH;
              end else if (rx_data == CMD_R || rx_data == (CMD_R | 8'h20)) begin
                is_wr <= 1'b0;
                state <= GET_CH;
              end else if (rx_data != CR) begin
                state <= SKIP;
              end
            end
          end
          EXEC: begin
            if (is_wr) begin
              for (int i = 0; i < NUM_CH; i++)
                if (ch == 4'(i)) begin
                  duty_q[i]  <= {hi, lo};
                  duty_wr[i] <= 1'b1;
                end
              rq[0]   <= ACK;
              rq_last <= 2'd0;
            end else begin
              rq[0]   <= nib2hex(sel_duty[7:4]);
              rq[1]   <= nib2hex(sel_duty[3:0]);
              rq[2]   <= CR;
              rq_last <= 2'd2;
            end
            rq_idx <= 2'd0;
            state  <= TX_SEND;
          end
          TX_SEND: begin
            if (!tx_busy) begin
              tx_start <= 1'b1;
              tx_data  <= rq[rq_idx];
              state    <= TX_HOLD;
            end
          end
          // One dead cycle so the UART has time to raise tx_busy.
          TX_HOLD: state <= TX_WAIT;
          TX_WAIT: begin
            if (!tx_busy) begin
              if (rq_idx == rq_last) state <= IDLE;
              else begin
                rq_idx <= rq_idx + 2'd1;
                state  <= TX_SEND;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_cmd_ctrl.sv
module tb_pwm_cmd_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_error = 1'b0;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] duty;
  logic [3:0]  duty_wr;
  logic        busy;

  logic        ext_busy = 1'b0;
  int          ucnt = 0;
  logic        prev_start = 1'b0;

  logic [7:0]  txq[$];
  logic        bq[$];
  logic        oq[$];
  logic [3:0]  wrq[$];

  int checks = 0;
  int errors = 0;

  pwm_cmd_ctrl #(.NUM_CH(4), .TIMEOUT_CYCLES(TO), .DUTY_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .duty(duty), .duty_wr(duty_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each accepted start.
  always @(posedge clk)
    if (tx_start) ucnt <= 10;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  assign tx_busy = ext_busy | (ucnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      txq.push_back(tx_data);
      bq.push_back(tx_busy);
      oq.push_back(prev_start);
    end
    if (|duty_wr) wrq.push_back(duty_wr);
    prev_start <= tx_start;
  end

  typedef struct {
    string       cmd;
    int          nrep;
    logic [7:0]  r0, r1, r2;
    logic [31:0] duty;
    logic [3:0]  wr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    send_byte(8'h0D);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s: busy still high after 3000 cycles", tag);
    end
    repeat (2) @(negedge clk);
  endtask

  // Compare reply bytes starting at queue index n0 against up to 3 expected.
  task automatic chk_reply(input string tag, input int n0, input int nrep,
                           input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
    logic [7:0] exp [3];
    exp[0] = r0; exp[1] = r1; exp[2] = r2;
    chk({tag, " n_replies"}, txq.size() - n0, nrep);
    for (int k = 0; k < nrep; k++) begin
      if (n0 + k < txq.size()) begin
        chk($sformatf("%s byte%0d", tag, k), {24'h0, txq[n0+k]}, {24'h0, exp[k]});
        chk($sformatf("%s start_while_busy%0d", tag, k), {31'h0, bq[n0+k]}, 32'h0);
        chk($sformatf("%s start_width%0d", tag, k), {31'h0, oq[n0+k]}, 32'h0);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n0, w0;
    n0 = txq.size();
    w0 = wrq.size();
    frame(v.cmd);
    wait_idle(v.cmd);
    chk_reply(v.cmd, n0, v.nrep, v.r0, v.r1, v.r2);
    chk({v.cmd, " duty"}, duty, v.duty);
    chk({v.cmd, " n_duty_wr"}, wrq.size() - w0, (v.wr != 4'h0) ? 1 : 0);
    if (v.wr != 4'h0 && wrq.size() > w0)
      chk({v.cmd, " duty_wr"}, {28'h0, wrq[w0]}, {28'h0, v.wr});
  endtask

  initial begin
    int n0;
    int n;
    vecs[0] = '{"P2A5", 1, 8'h4B, 8'h00, 8'h00, 32'h00A5_0000, 4'b0100};
    vecs[1] = '{"r2",   3, 8'h41, 8'h35, 8'h0D, 32'h00A5_0000, 4'b0000};
    vecs[2] = '{"P4FF", 1, 8'h3F, 8'h00, 8'h00, 32'h00A5_0000, 4'b0000};
    vecs[3] = '{"PxZ1", 1, 8'h3F, 8'h00, 8'h00, 32'h00A5_0000, 4'b0000};
    vecs[4] = '{"Q",    1, 8'h3F, 8'h00, 8'h00, 32'h00A5_0000, 4'b0000};
    vecs[5] = '{"P3c7", 1, 8'h4B, 8'h00, 8'h00, 32'hC7A5_0000, 4'b1000};
    vecs[6] = '{"R3",   3, 8'h43, 8'h37, 8'h0D, 32'hC7A5_0000, 4'b0000};
    vecs[7] = '{"r0",   3, 8'h30, 8'h30, 8'h0D, 32'hC7A5_0000, 4'b0000};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset duty", duty, 32'h0);
    chk("reset tx_start", {31'h0, tx_start}, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset duty_wr", {28'h0, duty_wr}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Timeout abandons a fragment silently
    n0 = txq.size();
    send_byte(8'h50);
    send_byte(8'h31);
    repeat (TO - 8) @(negedge clk);
    chk("busy before timeout", {31'h0, busy}, 32'h1);
    repeat (10) @(negedge clk);
    chk("busy after timeout", {31'h0, busy}, 32'h0);
    chk("timeout no reply", txq.size() - n0, 0);
    n0 = txq.size();
    frame("P13C");
    wait_idle("P13C");
    chk_reply("P13C", n0, 1, 8'h4B, 8'h00, 8'h00);
    chk("P13C duty", duty, 32'hC7A5_3C00);

    // rx_error mid-frame returns to idle with no reply
    n0 = txq.size();
    send_byte(8'h50);
    send_byte(8'h30);
    @(negedge clk);
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    chk("rx_error busy", {31'h0, busy}, 32'h0);
    repeat (5) @(negedge clk);
    chk("rx_error no reply", txq.size() - n0, 0);
    chk("rx_error duty", duty, 32'hC7A5_3C00);
    frame("p0ff");
    wait_idle("p0ff");
    chk_reply("p0ff", n0, 1, 8'h4B, 8'h00, 8'h00);
    chk("p0ff duty", duty, 32'hC7A5_3CFF);

    // Bytes during a stalled read reply are dropped
    n0 = txq.size();
    frame("R2");
    ext_busy = 1'b1;
    send_byte(8'h50);
    send_byte(8'h31);
    send_byte(8'h46);
    send_byte(8'h46);
    send_byte(8'h0D);
    repeat (10) @(negedge clk);
    chk("held by tx_busy", txq.size() - n0, 0);
    ext_busy = 1'b0;
    wait_idle("R2 stalled");
    chk_reply("R2 stalled", n0, 3, 8'h41, 8'h35, 8'h0D);
    chk("dropped write duty", duty, 32'hC7A5_3CFF);

    // Reset during TX_WAIT abandons the reply
    n0 = txq.size();
    frame("R1");
    n = 0;
    while (txq.size() == n0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("R1 first start seen", {31'h0, (txq.size() > n0)}, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset busy", {31'h0, busy}, 32'h0);
    chk("midreset tx_start", {31'h0, tx_start}, 32'h0);
    chk("midreset duty", duty, 32'h0);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midreset n_replies", txq.size() - n0, 1);
    if (txq.size() > n0) chk("midreset byte0", {24'h0, txq[n0]}, 32'h33);
    chk("midreset idle", {31'h0, busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_cmd_ctrl.md
Name: pwm_cmd_ctrl

Overview:
- Command sequencer between the UART core and a bank of PWM duty registers.
- Parses ASCII frames from the UART receive strobe/byte interface, then writes or reads per-channel 8-bit duty values.
- Sends a reply through the UART transmit handshake.
- Replaces ad-hoc "received byte = duty" wiring with framed, multi-channel, error-checked configuration.

Parameters:
- NUM_CH, 4, number of PWM channels (1..10; channel selected by ASCII '0'..'9').
- TIMEOUT_CYCLES, 1200000, inter-byte timeout in clk cycles (100 ms at 12 MHz).
- DUTY_RESET, 8'h00, duty value loaded into every channel at reset.

Ports:
- clk  in  1  system clock (12 MHz)
- rst_n  in  1  synchronous active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data valid (UART received)
- rx_data  in  8  received byte
- rx_error  in  1  UART receive error
- tx_busy  in  1  UART is_transmitting
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  byte to transmit, stable while tx_start high
- duty  out  NUM_CH*8  packed duty registers, channel n at [8n+7:8n]
- duty_wr  out  NUM_CH  one-cycle pulse on the channel just written
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset, synchronous on rst_n=0 at the clk edge:
  - every duty field = DUTY_RESET; tx_start=0, tx_data=0, duty_wr=0, busy=0.
  - FSM to IDLE; timeout counter cleared.
  - Reset mid-frame or mid-reply abandons it. No partial write.
- Frame grammar:
  - Write: 'P' ch hh CR
  - Read: 'R' ch CR
  - Command letter is case-insensitive. hh is two hex digits, high nibble first; a-f and A-F both accepted. CR = 8'h0D.
- States: IDLE, GET_CH, GET_HI, GET_LO, GET_END, SKIP, EXEC, TX_SEND, TX_HOLD, TX_WAIT.
- IDLE:
  - 'P'/'p' -> GET_CH (write); 'R'/'r' -> GET_CH (read).
  - CR ignored, stays IDLE.
  - Any other byte -> SKIP.
- GET_CH:
  - digit < NUM_CH latches ch, then -> GET_HI (write) or GET_END (read).
  - Otherwise -> SKIP.
- GET_HI / GET_LO: valid hex digit latches the nibble; any other byte -> SKIP.
- GET_END: CR -> EXEC; any other byte -> SKIP.
- SKIP: discards bytes until CR, then queues reply '?' (8'h3F) -> TX_SEND.
- EXEC, one cycle:
  - Write: duty[ch] <= {hi,lo}, duty_wr[ch]=1 this cycle, queue reply 'K' (8'h4B).
  - Read: queue 3 bytes: ASCII upper-case hex of duty[ch] high nibble, low nibble, then CR.
  - -> TX_SEND.
- Transmit handshake, per queued byte:
  - TX_SEND waits tx_busy=0, then drives tx_start=1 for exactly one cycle with tx_data -> TX_HOLD.
  - TX_HOLD lasts one cycle, covering the UART busy-rise latency -> TX_WAIT.
  - TX_WAIT waits tx_busy=0, then goes to the next queued byte or IDLE.
  - Reply queue depth 3, index counter 0..2.
- rx_valid during EXEC or TX_*: byte dropped, no state effect.
- Timeout:
  - Counter runs in GET_*/SKIP and is cleared on every rx_valid.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE silently, no reply.
- rx_error high in any cycle of GET_* or SKIP -> IDLE silently. In other states it is ignored.
- If rx_valid and rx_error are high in the same cycle, rx_error wins: byte discarded.
- A write takes effect at the EXEC edge, before the 'K' is sent. A read returns the value after any preceding write.
- Latency: CR accepted at edge N -> duty updated at edge N+1 -> tx_start high at edge N+2 if tx_busy=0.

Decomposition:
- Package pwm_cmd_pkg holds:
  - state enum;
  - byte constants CMD_W='P', CMD_R='R', CR=8'h0D, ACK='K', NAK='?';
  - functions hex2nib (returns valid flag + nibble), nib2hex, is_digit.
- No sub-module. FSM, reply queue, timeout counter and duty bank live in one module (~200 lines).

Test Plan:
- Reset: duty=32'h0 and tx_start=0 after rst_n low 2 cycles. Send "P2A5\r" -> duty[23:16]=8'hA5, duty_wr=4'b0100 for 1 cycle, reply 8'h4B, other channels still 8'h00.
- Read-back: after the write above, send "r2\r" -> tx bytes 'A','5',8'h0D in order; each tx_start only when tx_busy=0, 1 cycle wide.
- Errors, each with no duty change:
  - "P4FF\r" (ch out of range) -> reply 8'h3F.
  - "PxZ1\r" -> reply 8'h3F.
  - "Q\r" -> reply 8'h3F.
- Timeout: send "P1", idle TIMEOUT_CYCLES cycles, then "P13C\r" -> no reply to the fragment; duty[15:8]=8'h3C, single 'K'.
- rx_error pulse after "P0" -> IDLE with no reply. Then "p0ff\r" -> duty[7:0]=8'hFF, 'K'.
- Bytes sent while tx_busy=1 during a read reply are dropped, reply is not corrupted. rst_n low during TX_WAIT -> busy=0, tx_start=0, no further bytes.
